sram_boot_ctr: RTL

- Sits directly upstream of the dual-port SRAM instruction port.
- After reset it copies a firmware image from a synchronous boot ROM into SRAM through the instruction port's write strobes, holding the CPU in reset meanwhile.
- Once the copy is complete it releases the CPU and becomes a transparent pass-through between the CPU instruction bus and the SRAM instruction port.

---
 rtl/sram_boot_ctr.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sram_boot_ctr.sv
`default_nettype none
// ============================================================================
// Module : sram_boot_ctr
// Copies a boot-ROM image into SRAM after reset with the CPU held in reset,
// then passes CPU instruction fetches straight through to the SRAM port.
// Rev    : 1.0
// ============================================================================
module sram_boot_ctr #(
  parameter int DATA_W      = 32,
  parameter int SRAM_ADDR_W = 15,
  parameter int ROM_ADDR_W  = 12,
  parameter int BOOT_WORDS  = 1024,
  parameter int SRAM_BASE   = 0
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic                     cke_i,
  input  logic                     boot_restart_i,
  output logic                     rom_en_o,
  output logic [ROM_ADDR_W-1:0]    rom_addr_o,
  input  logic [DATA_W-1:0]        rom_rdata_i,
  output logic                     sram_avalid_o,
  output logic [SRAM_ADDR_W-3:0]   sram_addr_o,
  output logic [DATA_W-1:0]        sram_wdata_o,
  output logic [DATA_W/8-1:0]      sram_wstrb_o,
  input  logic [DATA_W-1:0]        sram_rdata_i,
  input  logic                     sram_rvalid_i,
  input  logic                     cpu_avalid_i,
  input  logic [SRAM_ADDR_W-3:0]   cpu_addr_i,
  output logic [DATA_W-1:0]        cpu_rdata_o,
  output logic                     cpu_rvalid_o,
  output logic                     cpu_ready_o,
  output logic                     cpu_rst_o,
  output logic                     boot_done_o
);

  localparam int              c_aw    = SRAM_ADDR_W - 2;
  localparam int              c_cw    = ROM_ADDR_W + 1;
  localparam bit              c_empty = (BOOT_WORDS == 0);
  localparam logic [c_cw-1:0] c_last  = c_cw'(c_empty ? 0 : BOOT_WORDS - 1);
  localparam logic [c_aw-1:0] c_base  = c_aw'(SRAM_BASE);

  typedef enum logic [1:0] {
    ST_COPY  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [c_cw-1:0] r_rd_cnt;
  logic            r_wr_pend;
  logic            r_run_q;
  logic            r_cpu_rst;
  logic            r_boot_done;
  logic            r_cpu_ready;
  logic            w_rom_rd;
  logic            w_restart;
  logic [c_aw-1:0] w_wr_addr;

  assign w_rom_rd  = (r_state == ST_COPY) && !c_empty;
  assign w_restart = (r_state == ST_RUN) && boot_restart_i;
  // The word being written is the one read on the previous cycle.
  assign w_wr_addr = c_base + c_aw'(r_rd_cnt) - c_aw'(1);

  // Enable is forced low while reset is held so the ROM sees no access.
  assign rom_en_o     = w_rom_rd && arst_n_i;
  assign rom_addr_o   = r_rd_cnt[ROM_ADDR_W-1:0];
  assign cpu_rvalid_o = sram_rvalid_i && r_run_q;
  assign cpu_ready_o  = r_cpu_ready;
  assign cpu_rst_o    = r_cpu_rst;
  assign boot_done_o  = r_boot_done;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= ST_COPY;
    end else if (cke_i) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_COPY: begin
        if (c_empty) begin
          w_next = ST_RUN;
        end else if (r_rd_cnt == c_last) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: w_next = ST_RUN;
      ST_RUN: begin
        if (boot_restart_i) begin
          w_next = ST_COPY;
        end
      end
      default: w_next = ST_COPY;
    endcase
  end

  always_comb begin
    sram_avalid_o = r_wr_pend;
    sram_addr_o   = w_wr_addr;
    sram_wdata_o  = r_wr_pend ? rom_rdata_i : '0;
    sram_wstrb_o  = {(DATA_W/8){r_wr_pend}};
    cpu_rdata_o   = '0;
    if (r_state == ST_RUN) begin
      sram_avalid_o = cpu_avalid_i;
      sram_addr_o   = cpu_addr_i;
      sram_wdata_o  = '0;
      sram_wstrb_o  = '0;
      cpu_rdata_o   = sram_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_rd_cnt    <= '0;
      r_wr_pend   <= 1'b0;
      r_run_q     <= 1'b0;
      r_cpu_rst   <= 1'b1;
      r_boot_done <= 1'b0;
      r_cpu_ready <= 1'b0;
    end else if (cke_i) begin
      if (w_restart) begin
        r_rd_cnt <= '0;
      end else if (w_rom_rd) begin
        r_rd_cnt <= r_rd_cnt + c_cw'(1);
      end
      r_wr_pend   <= w_rom_rd;
      // Cleared on a restart so a fetch issued in that cycle never completes.
      r_run_q     <= (r_state == ST_RUN) && (w_next == ST_RUN);
      r_cpu_rst   <= (w_next != ST_RUN);
      r_boot_done <= (w_next == ST_RUN);
      r_cpu_ready <= (w_next == ST_RUN);
    end
  end

endmodule
`default_nettype wire
